julia_worker: RTL and testbench

JULIA_WORKER -- requirements
Module: julia_worker

---
 rtl/julia_pkg.sv | 27 ++
 rtl/julia_worker_if.sv | 27 ++
 rtl/julia_step.sv | 35 +++
 rtl/julia_worker.sv | 119 +++++++++++
 tb/tb_julia_worker.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/julia_pkg.sv
// rtl/julia_pkg.sv - shared types and constants for the Julia-set pixel worker
package julia_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int FRAC     = 12;
   localparam int COORD_W  = 10;
   localparam int FIX_W    = 16;
   localparam int CENTRE_X = 320;
   localparam int CENTRE_Y = 240;

   // |z|^2 >= 4.0 expressed in the Q8.24 product domain
   localparam logic signed [32:0] ESC_THRESH = 33'sd67108864;

   // Pixel coordinate to signed Q4.12 start value: one pixel is 1/256 of a unit
   function automatic logic signed [FIX_W-1:0] centre_offset(input logic [COORD_W-1:0] p,
                                                             input int centre);
      logic signed [FIX_W-1:0] d;
      d = $signed({6'b0, p}) - 16'(centre);
      return d <<< 4;
   endfunction

endpackage

// File: rtl/julia_worker_if.sv
// rtl/julia_worker_if.sv - dispatch job and result handshake bundle for julia_worker
interface julia_worker_if;
   import julia_pkg::*;

   logic                     dp_jw_start;
   logic [COORD_W-1:0]       x_in;
   logic [COORD_W-1:0]       y_in;
   logic signed [FIX_W-1:0]  c_re;
   logic signed [FIX_W-1:0]  c_im;
   logic                     jw_dp_ready;
   logic                     res_valid;
   logic                     res_ready;
   logic [COORD_W-1:0]       res_x;
   logic [COORD_W-1:0]       res_y;
   logic [7:0]               res_iter;

   modport master (
      output dp_jw_start, x_in, y_in, c_re, c_im, res_ready,
      input  jw_dp_ready, res_valid, res_x, res_y, res_iter
   );

   modport slave (
      input  dp_jw_start, x_in, y_in, c_re, c_im, res_ready,
      output jw_dp_ready, res_valid, res_x, res_y, res_iter
   );

endinterface

// File: rtl/julia_step.sv
// rtl/julia_step.sv - one combinational z*z+c step with escape test
module julia_step #(
   parameter int FRAC = 12
) (
   input  logic signed [15:0] z_re_i,
   input  logic signed [15:0] z_im_i,
   input  logic signed [15:0] c_re_i,
   input  logic signed [15:0] c_im_i,
   output logic signed [15:0] nz_re_o,
   output logic signed [15:0] nz_im_o,
   output logic               escape_o
);
   import julia_pkg::*;

   logic signed [31:0] zr2;
   logic signed [31:0] zi2;
   logic signed [31:0] zri;
   logic signed [32:0] mag;
   logic signed [32:0] diff;
   logic signed [32:0] twice;

   // Q8.24 products; the 33-bit sums cannot overflow for any 16-bit operands
   always_comb begin
      zr2      = z_re_i * z_re_i;
      zi2      = z_im_i * z_im_i;
      zri      = z_re_i * z_im_i;
      mag      = 33'(zr2) + 33'(zi2);
      diff     = 33'(zr2) - 33'(zi2);
      twice    = {zri, 1'b0};
      escape_o = (mag >= ESC_THRESH);
      nz_re_o  = 16'((diff  >>> FRAC) + 33'(c_re_i));
      nz_im_o  = 16'((twice >>> FRAC) + 33'(c_im_i));
   end

endmodule

// File: rtl/julia_worker.sv
// rtl/julia_worker.sv - per-pixel Julia iteration worker; JULIA_WORKER_PERF_EN adds perf_busy
module julia_worker #(
   parameter int MAX_ITER = 255,
   parameter int FRAC     = julia_pkg::FRAC
) (
   input  logic          clk,
   input  logic          rst,
   julia_worker_if.slave jw
`ifdef JULIA_WORKER_PERF_EN
   ,
   output logic [31:0]   perf_busy
`endif
);
   import julia_pkg::*;

   localparam logic [7:0] ITER_CAP = 8'(MAX_ITER);

   state_e                  state_q, state_d;
   logic [COORD_W-1:0]      x_q, x_d, y_q, y_d;
   logic signed [FIX_W-1:0] cre_q, cre_d, cim_q, cim_d;
   logic signed [FIX_W-1:0] zre_q, zre_d, zim_q, zim_d;
   logic [7:0]              iter_q, iter_d;

   logic signed [FIX_W-1:0] nz_re, nz_im;
   logic                    escape;

   julia_step #(.FRAC(FRAC)) u_step (
      .z_re_i   (zre_q),
      .z_im_i   (zim_q),
      .c_re_i   (cre_q),
      .c_im_i   (cim_q),
      .nz_re_o  (nz_re),
      .nz_im_o  (nz_im),
      .escape_o (escape)
   );

   assign jw.jw_dp_ready = (state_q == IDLE);
   assign jw.res_valid   = (state_q == DONE);
   assign jw.res_x       = x_q;
   assign jw.res_y       = y_q;
   assign jw.res_iter    = iter_q;

   // Job state and datapath registers; reset discards any job in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         cre_q   <= '0;
         cim_q   <= '0;
         zre_q   <= '0;
         zim_q   <= '0;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cre_q   <= cre_d;
         cim_q   <= cim_d;
         zre_q   <= zre_d;
         zim_q   <= zim_d;
         iter_q  <= iter_d;
      end
   end

   // Next state: capture in IDLE, step z in ITER until escape or cap, hold in DONE
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cre_d   = cre_q;
      cim_d   = cim_q;
      zre_d   = zre_q;
      zim_d   = zim_q;
      iter_d  = iter_q;
      case (state_q)
         IDLE: begin
            if (jw.dp_jw_start) begin
               x_d     = jw.x_in;
               y_d     = jw.y_in;
               cre_d   = jw.c_re;
               cim_d   = jw.c_im;
               zre_d   = centre_offset(jw.x_in, CENTRE_X);
               zim_d   = centre_offset(jw.y_in, CENTRE_Y);
               iter_d  = '0;
               state_d = ITER;
            end
         end
         ITER: begin
            // The cap test comes first so iter can never pass MAX_ITER
            if (escape || (iter_q == ITER_CAP)) begin
               state_d = DONE;
            end else begin
               zre_d  = nz_re;
               zim_d  = nz_im;
               iter_d = iter_q + 8'd1;
            end
         end
         DONE: begin
            if (jw.res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef JULIA_WORKER_PERF_EN
   // Saturating count of cycles spent iterating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_busy <= '0;
      end else if ((state_q == ITER) && (perf_busy != 32'hFFFF_FFFF)) begin
         perf_busy <= perf_busy + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_julia_worker.sv
// tb/tb_julia_worker.sv - self-checking bench for julia_worker with a reference escape-time model
module tb_julia_worker;

   localparam int MAX_ITER = 255;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   julia_worker_if jif();

`ifdef JULIA_WORKER_PERF_EN
   logic [31:0] perf_busy;
`endif

   julia_worker #(.MAX_ITER(MAX_ITER), .FRAC(12)) dut (
      .clk (clk),
      .rst (rst),
      .jw  (jif)
`ifdef JULIA_WORKER_PERF_EN
      ,
      .perf_busy (perf_busy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint wrap16(input longint v);
      logic [15:0] t;
      t = v[15:0];
      return longint'($signed(t));
   endfunction

   // Escape-time count straight from the fixed-point rules
   function automatic int model_iter(input int x, input int y, input int cr, input int ci);
      longint zr, zi, nr, ni;
      zr = longint'(x - 320) * 16;
      zi = longint'(y - 240) * 16;
      for (int n = 0; n <= MAX_ITER; n++) begin
         if (zr * zr + zi * zi >= (longint'(4) << 24)) return n;
         if (n == MAX_ITER) return n;
         nr = ((zr * zr - zi * zi) >>> 12) + cr;
         ni = ((2 * zr * zi) >>> 12) + ci;
         zr = wrap16(nr);
         zi = wrap16(ni);
      end
      return MAX_ITER;
   endfunction

   // Issue one job; returns cycles from capture edge until res_valid is seen
   task automatic run_job(input int x, input int y, input int cr, input int ci,
                          input int stray_at, output int cnt);
      @(negedge clk);
      jif.dp_jw_start = 1'b1;
      jif.x_in        = 10'(x);
      jif.y_in        = 10'(y);
      jif.c_re        = 16'(cr);
      jif.c_im        = 16'(ci);
      @(posedge clk);
      #1;
      jif.dp_jw_start = 1'b0;
      check("ready_low_after_start", jif.jw_dp_ready, 0);
      cnt = 0;
      while (cnt < 400) begin
         @(posedge clk);
         #1;
         cnt++;
         jif.dp_jw_start = 1'b0;
         if (jif.res_valid) break;
         if (cnt == stray_at) begin
            jif.dp_jw_start = 1'b1;
            jif.x_in        = 10'd100;
            jif.y_in        = 10'd7;
         end
      end
      if (!jif.res_valid) check("result_timeout", jif.res_valid, 1);
   endtask

   initial begin
      int cnt, n, x, y, cr, ci, seen;
      logic [9:0] hx, hy;
      logic [7:0] hi;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      jif.dp_jw_start = 1'b0;
      jif.x_in = '0;
      jif.y_in = '0;
      jif.c_re = '0;
      jif.c_im = '0;
      jif.res_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", jif.jw_dp_ready, 1);
      check("rst_valid", jif.res_valid, 0);
      check("rst_x", jif.res_x, 0);
      check("rst_y", jif.res_y, 0);
      check("rst_iter", jif.res_iter, 0);
`ifdef JULIA_WORKER_PERF_EN
      check("rst_perf", perf_busy, 0);
`endif
      rst = 1'b0;

      // Centre pixel, c=0: never escapes, hits the cap
      run_job(320, 240, 0, 0, -1, cnt);
      check("cap_iter", jif.res_iter, 255);
      check("cap_latency", cnt, 256);
      check("cap_x", jif.res_x, 320);
      check("cap_y", jif.res_y, 240);
      @(posedge clk); #1;
      check("cap_ready_back", jif.jw_dp_ready, 1);
      check("cap_valid_gone", jif.res_valid, 0);

      // c=2.0: z1=2.0 sits exactly on the escape threshold
      run_job(320, 240, 'h2000, 0, -1, cnt);
      check("edge_iter", jif.res_iter, 1);
      check("edge_latency", cnt, 2);
      @(posedge clk); #1;
`ifdef JULIA_WORKER_PERF_EN
      check("perf_busy", perf_busy, 258);
`endif

      // Held result under back-pressure
      jif.res_ready = 1'b0;
      run_job(0, 240, 'h1000, 0, -1, cnt);
      check("hold_iter", jif.res_iter, 1);
      check("hold_latency", cnt, 2);
      hx = jif.res_x; hy = jif.res_y; hi = jif.res_iter;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("hold_valid", jif.res_valid, 1);
         check("hold_ready_low", jif.jw_dp_ready, 0);
         check("hold_stable", {jif.res_x, jif.res_y, jif.res_iter}, {hx, hy, hi});
      end
      check("hold_x", hx, 0);
      jif.res_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_release_ready", jif.jw_dp_ready, 1);

      // Stray start during ITER is ignored
      run_job(320, 240, 0, 0, 20, cnt);
      check("stray_x", jif.res_x, 320);
      check("stray_y", jif.res_y, 240);
      check("stray_iter", jif.res_iter, 255);
      check("stray_latency", cnt, 256);
      @(posedge clk); #1;

      // Reset mid-job discards it
      @(negedge clk);
      jif.dp_jw_start = 1'b1;
      jif.x_in = 10'd320; jif.y_in = 10'd240; jif.c_re = '0; jif.c_im = '0;
      @(negedge clk);
      jif.dp_jw_start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_ready", jif.jw_dp_ready, 1);
      check("midrst_valid", jif.res_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (jif.res_valid || !jif.jw_dp_ready) seen++;
      end
      check("midrst_no_result", seen, 0);
      run_job(320, 240, 'h2000, 0, -1, cnt);
      check("postrst_iter", jif.res_iter, 1);
      check("postrst_latency", cnt, 2);
      @(posedge clk); #1;

      // Random jobs against the model
      for (int j = 0; j < 16; j++) begin
         x  = int'($urandom_range(0, 639));
         y  = int'($urandom_range(0, 479));
         cr = int'($urandom_range(0, 16383)) - 8192;
         ci = int'($urandom_range(0, 16383)) - 8192;
         if (j < 4) begin
            x = 320 + int'($urandom_range(0, 40)) - 20;
            y = 240 + int'($urandom_range(0, 40)) - 20;
            cr = int'($urandom_range(0, 4095)) - 2048;
            ci = int'($urandom_range(0, 4095)) - 2048;
         end
         n = model_iter(x, y, cr, ci);
         run_job(x, y, cr, ci, -1, cnt);
         check("rand_iter", jif.res_iter, n);
         check("rand_latency", cnt, n + 1);
         check("rand_x", jif.res_x, x);
         check("rand_y", jif.res_y, y);
         @(posedge clk); #1;
         check("rand_ready_back", jif.jw_dp_ready, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
